// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: a circular FIFO of pending
// stores with youngest-match load forwarding, load/store port arbitration
// and a fence-style flush.
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   capture_store, store_*      store enqueue request (addr/data/byte enables)
//   load_request, load_addr     MEM-stage load probing the buffer
//   flush_req                   pulse: drain every entry, then flush_done
//   mem_wr_ready                memory accepts the presented write
//   wr_enable, wr_addr,
//   wr_data, write_byte_enable  head entry presented to memory
//   buffer_forward_valid/data   forwarded load data (full-word hit)
//   forward_stall               load hits a partially written word
//   buffer_full, buffer_empty   occupancy flags (state only)
//   flush_done                  one-cycle pulse when a flush finishes
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_store,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    input  logic [3:0]  store_byte_en,
    input  logic        load_request,
    input  logic [31:0] load_addr,
    input  logic        flush_req,
    input  logic        mem_wr_ready,
    output logic        wr_enable,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  write_byte_enable,
    output logic        buffer_forward_valid,
    output logic [31:0] buffer_forward_data,
    output logic        forward_stall,
    output logic        buffer_full,
    output logic        buffer_empty,
    output logic        flush_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q;
    logic [31:0]       addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              flush_done_q;

    logic              full;
    logic              empty;
    logic              drain;
    logic              enq;

    logic              fwd_hit;
    logic [PW-1:0]     fwd_idx;
    logic [PW-1:0]     scan_idx;
    logic              fwd_word;

    logic              unused_addr_lsb;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign buffer_full  = full;
    assign buffer_empty = empty;
    assign flush_done   = flush_done_q;

    // Loads own the memory port in RUN unless the buffer is full, so a
    // full buffer can always make progress.
    assign wr_enable = !empty &&
                       (state_q == FLUSH || !load_request || full);

    assign drain = wr_enable && mem_wr_ready;
    // A same-cycle drain frees the slot the new store will occupy.
    assign enq   = capture_store && (!full || drain);

    assign wr_addr           = empty ? '0 : addr_q[head_q];
    assign wr_data           = empty ? '0 : data_q[head_q];
    assign write_byte_enable = empty ? '0 : be_q[head_q];

    always_comb begin
        count_d = count_q;
        if (enq && !drain) begin
            count_d = count_q + CW'(1);
        end else if (drain && !enq) begin
            count_d = count_q - CW'(1);
        end
    end

    // Scan oldest to youngest; the last match seen is the youngest.
    // The draining head still counts, a store being captured does not.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && valid_q[scan_idx] &&
                (addr_q[scan_idx][31:2] == load_addr[31:2])) begin
                fwd_hit = 1'b1;
                fwd_idx = scan_idx;
            end
        end
    end

    assign fwd_word = (be_q[fwd_idx] == 4'b1111);

    assign buffer_forward_valid = load_request && fwd_hit && fwd_word;
    assign buffer_forward_data  = buffer_forward_valid ?
                                  data_q[fwd_idx] : '0;
    assign forward_stall        = load_request && fwd_hit && !fwd_word;

    assign unused_addr_lsb = ^load_addr[1:0];

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= store_addr;
            data_q[tail_q] <= store_data;
            be_q[tail_q]   <= store_byte_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            state_q      <= RUN;
            flush_done_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            flush_done_q <= 1'b0;
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            // Enqueue after the clear: when full, tail and head coincide.
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
            unique case (state_q)
                RUN: begin
                    if (flush_req) begin
                        // Nothing left after this edge: finish at once.
                        if (empty || count_d == '0) begin
                            flush_done_q <= 1'b1;
                        end else begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (count_d == '0) begin
                        state_q      <= RUN;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture_store;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic [3:0]  store_byte_en;
    logic        load_request;
    logic [31:0] load_addr;
    logic        flush_req;
    logic        mem_wr_ready;
    logic        wr_enable;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  write_byte_enable;
    logic        buffer_forward_valid;
    logic [31:0] buffer_forward_data;
    logic        forward_stall;
    logic        buffer_full;
    logic        buffer_empty;
    logic        flush_done;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .capture_store        (capture_store),
        .store_addr           (store_addr),
        .store_data           (store_data),
        .store_byte_en        (store_byte_en),
        .load_request         (load_request),
        .load_addr            (load_addr),
        .flush_req            (flush_req),
        .mem_wr_ready         (mem_wr_ready),
        .wr_enable            (wr_enable),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .write_byte_enable    (write_byte_enable),
        .buffer_forward_valid (buffer_forward_valid),
        .buffer_forward_data  (buffer_forward_data),
        .forward_stall        (forward_stall),
        .buffer_full          (buffer_full),
        .buffer_empty         (buffer_empty),
        .flush_done           (flush_done)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t        q[$];
    bit          m_flush;
    bit          m_done;
    logic [31:0] wlog[$];
    int          cyc;
    int          done_cyc;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic eval(input bit upd);
        bit          full_e;
        bit          empty_e;
        bit          wr_e;
        bit          fv;
        bit          fs;
        logic [31:0] fd;
        bit          drn;
        bit          enq;
        int          old;
        ent_t        e;
        full_e  = (q.size() == DEPTH);
        empty_e = (q.size() == 0);
        wr_e    = !empty_e && (m_flush || !load_request || full_e);
        fv = 0;
        fs = 0;
        fd = '0;
        if (load_request) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a[31:2] == load_addr[31:2]) begin
                    if (q[i].be == 4'hF) begin
                        fv = 1;
                        fd = q[i].d;
                    end else begin
                        fs = 1;
                    end
                    break;
                end
            end
        end
        chk("wr_enable", {31'd0, wr_enable}, {31'd0, wr_e});
        chk("wr_addr", wr_addr, empty_e ? 32'd0 : q[0].a);
        chk("wr_data", wr_data, empty_e ? 32'd0 : q[0].d);
        chk("wr_be", {28'd0, write_byte_enable},
            empty_e ? 32'd0 : {28'd0, q[0].be});
        chk("fwd_valid", {31'd0, buffer_forward_valid}, {31'd0, fv});
        chk("fwd_data", buffer_forward_data, fd);
        chk("fwd_stall", {31'd0, forward_stall}, {31'd0, fs});
        chk("full", {31'd0, buffer_full}, {31'd0, full_e});
        chk("empty", {31'd0, buffer_empty}, {31'd0, empty_e});
        chk("flush_done", {31'd0, flush_done}, {31'd0, m_done});
        if (upd) begin
            if (wr_enable === 1'b1 && mem_wr_ready === 1'b1)
                wlog.push_back(wr_addr);
            if (flush_done === 1'b1)
                done_cyc = cyc;
            drn = wr_e && mem_wr_ready;
            enq = capture_store && (!full_e || drn);
            old = q.size();
            if (drn)
                void'(q.pop_front());
            if (enq) begin
                e.a  = store_addr;
                e.d  = store_data;
                e.be = store_byte_en;
                q.push_back(e);
            end
            if (!m_flush && flush_req) begin
                if (old == 0 || q.size() == 0) begin
                    m_done = 1;
                end else begin
                    m_done  = 0;
                    m_flush = 1;
                end
            end else if (m_flush && q.size() == 0) begin
                m_flush = 0;
                m_done  = 1;
            end else begin
                m_done = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        eval(1'b1);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drv(input bit cap, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input bit ld, input logic [31:0] la,
                       input bit fl, input bit rdy);
        capture_store = cap;
        store_addr    = a;
        store_data    = d;
        store_byte_en = be;
        load_request  = ld;
        load_addr     = la;
        flush_req     = fl;
        mem_wr_ready  = rdy;
    endtask

    task automatic model_reset();
        q.delete();
        m_flush = 0;
        m_done  = 0;
    endtask

    initial begin
        int c0;
        int nb;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        done_cyc = -1;
        model_reset();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        eval(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // basic drain
        drv(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("basic_wr_en", {31'd0, wr_enable}, 32'd1);
        chk("basic_wr_addr", wr_addr, 32'h100);
        chk("basic_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        chk("basic_empty", {31'd0, buffer_empty}, 32'd1);
        tick();

        // forwarding
        drv(1, 32'h200, 32'h11111111, 4'hF, 0, 0, 0, 0);
        tick();
        drv(1, 32'h200, 32'h22222222, 4'hF, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 1, 32'h200, 0, 0);
        #1;
        chk("fwd_200_valid", {31'd0, buffer_forward_valid}, 32'd1);
        chk("fwd_200_data", buffer_forward_data, 32'h22222222);
        tick();
        drv(0, 0, 0, 0, 1, 32'h202, 0, 0);
        #1;
        chk("fwd_202_data", buffer_forward_data, 32'h22222222);
        tick();
        drv(1, 32'h204, 32'h000000AB, 4'b0001, 1, 32'h204, 0, 0);
        #1;
        chk("fwd_same_cycle", {31'd0, forward_stall}, 32'd0);
        tick();
        drv(0, 0, 0, 0, 1, 32'h204, 0, 0);
        #1;
        chk("fwd_204_stall", {31'd0, forward_stall}, 32'd1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) tick();

        // full and arbitration
        for (int i = 0; i < 4; i++) begin
            drv(1, 32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF,
                0, 0, 0, 0);
            tick();
        end
        chk("full_after4", {31'd0, buffer_full}, 32'd1);
        drv(1, 32'h510, 32'hBAD, 4'hF, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 1, 32'h600, 0, 0);
        #1;
        chk("full_wr_en_ld", {31'd0, wr_enable}, 32'd1);
        tick();
        wlog.delete();
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (5) tick();
        chk("full_nwrites", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("full_order", wlog[i], 32'h500 + 32'(4 * i));

        // wrap with simultaneous enqueue/drain
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            drv(1, 32'h400 + 32'(4 * i), 32'(i), 4'hF, 0, 0, 0, 1);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        chk("wrap_nwrites", 32'(wlog.size()), 32'd10);
        for (int i = 0; i < 10 && i < wlog.size(); i++)
            chk("wrap_order", wlog[i], 32'h400 + 32'(4 * i));

        // flush with load held
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'h700 + 32'(4 * i), 32'(i), 4'hF, 0, 0, 0, 0);
            tick();
        end
        wlog.delete();
        done_cyc = -1;
        drv(0, 0, 0, 0, 1, 32'h900, 1, 1);
        c0 = cyc;
        tick();
        drv(0, 0, 0, 0, 1, 32'h900, 0, 1);
        repeat (5) tick();
        chk("flush_nwrites", 32'(wlog.size()), 32'd3);
        chk("flush_done_cyc", 32'(done_cyc), 32'(c0 + 4));

        // flush while empty
        done_cyc = -1;
        drv(0, 0, 0, 0, 0, 0, 1, 1);
        c0 = cyc;
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        chk("eflush_done_cyc", 32'(done_cyc), 32'(c0 + 1));

        // reset mid-flush with entries pending
        for (int i = 0; i < 2; i++) begin
            drv(1, 32'h800 + 32'(4 * i), 32'(i), 4'hF, 0, 0, 0, 0);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("rst_wr_en", {31'd0, wr_enable}, 32'd0);
        chk("rst_empty", {31'd0, buffer_empty}, 32'd1);
        model_reset();
        tick();
        rst = 1'b1;
        nb = wlog.size();
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) tick();
        chk("rst_no_write", 32'(wlog.size() - nb), 32'd0);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            drv($urandom_range(0, 1) == 1,
                32'h300 + 32'(4 * $urandom_range(0, 3)) +
                    32'($urandom_range(0, 3)),
                $urandom(),
                ($urandom_range(0, 1) == 1) ? 4'hF :
                    4'($urandom_range(1, 14)),
                $urandom_range(0, 1) == 1,
                32'h300 + 32'(4 * $urandom_range(0, 4)) +
                    32'($urandom_range(0, 3)),
                $urandom_range(0, 31) == 0,
                $urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries (power of two, >=2).
REQ-002 SHALL have ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- capture_store  input  1  enqueue store this cycle
- store_addr  input  32  store byte address
- store_data  input  32  store data, low-aligned as formatted by the MEM stage
- store_byte_en  input  4  store byte enables
- load_request  input  1  MEM stage issues a load this cycle
- load_addr  input  32  load byte address
- flush_req  input  1  pulse: drain all entries before proceeding (fence)
- mem_wr_ready  input  1  data memory accepts the write this cycle
- wr_enable  output  1  memory write strobe
- wr_addr  output  32  memory write address
- wr_data  output  32  memory write data
- write_byte_enable  output  4  memory write byte enables
- buffer_forward_valid  output  1  forward_data is valid for the current load
- buffer_forward_data  output  32  forwarded load data
- forward_stall  output  1  load hits a partially covered entry and must wait
- buffer_full  output  1  no free entry
- buffer_empty  output  1  no valid entry
- flush_done  output  1  one-cycle pulse when a flush completes

Function
REQ-003 SHALL hold entries in a circular FIFO: head and tail pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits; pointers wrap from DEPTH-1 to 0.
REQ-004 SHALL enqueue {store_addr, store_data, store_byte_en} at tail on a clock edge where capture_store=1 and (count<DEPTH or a drain completes in the same cycle).
REQ-005 SHALL ignore capture_store when full with no same-cycle drain; upstream stalls on buffer_full.
REQ-006 SHALL present the head entry on wr_addr/wr_data/write_byte_enable whenever not empty; these outputs SHALL be 0 when empty.
REQ-007 SHALL implement the FSM states RUN and FLUSH.
REQ-008 In RUN, wr_enable SHALL be 1 when not empty and (load_request=0 or buffer_full=1); loads take the port unless the buffer is full.
REQ-009 In FLUSH, wr_enable SHALL be 1 whenever not empty, regardless of load_request.
REQ-010 A drain SHALL complete on an edge with wr_enable=1 and mem_wr_ready=1; head advances by one. The entry is held while mem_wr_ready=0.
REQ-011 Simultaneous enqueue and drain SHALL leave count unchanged.
REQ-012 FSM transitions:
- RUN to FLUSH when flush_req=1.
- FLUSH to RUN when count reaches 0.
- flush_req while already empty SHALL pulse flush_done on the next cycle and stay in RUN.
- flush_done SHALL be high for exactly one cycle, the cycle after the last drain completes.
REQ-013 Forwarding SHALL be combinational and evaluated when load_request=1. It compares load_addr[31:2] against valid entries' addr[31:2] and selects the youngest match, nearest the tail.
REQ-014 If the youngest match has byte_en=4'b1111: buffer_forward_valid=1, buffer_forward_data = that entry's data, forward_stall=0.
REQ-015 If the youngest match has byte_en other than 4'b1111: buffer_forward_valid=0 and forward_stall=1.
REQ-016 With no match, or load_request=0: buffer_forward_valid=0, buffer_forward_data=0, forward_stall=0.
REQ-017 The head entry draining in the current cycle SHALL still participate in forwarding that cycle.
REQ-018 A store enqueued in the current cycle SHALL NOT participate in forwarding until the next cycle.
REQ-019 buffer_full SHALL equal (count==DEPTH); buffer_empty SHALL equal (count==0). Both are registered-state derived, with no input combinational paths.

Reset
REQ-020 On rst=0, asynchronously:
- head, tail and count = 0; all entry valid bits = 0; FSM = RUN.
- wr_enable=0, buffer_full=0, buffer_empty=1, flush_done=0, forward outputs 0.
REQ-021 Reset mid-drain or mid-flush SHALL discard all entries without a completing write; no flush_done is produced.
REQ-022 Outputs SHALL be valid from the first edge after rst deasserts.

Verification
REQ-023 Bench SHALL cover these scenarios:
- Basic drain: enqueue SW addr 0x100 data 0xDEADBEEF be 1111, mem_wr_ready=1, no loads -> next cycle wr_enable=1, wr_addr=0x100, wr_data=0xDEADBEEF; empty one cycle later.
- Forwarding: enqueue SW 0x200=0x11111111 then SW 0x200=0x22222222; hold mem_wr_ready=0; load 0x200 -> buffer_forward_valid=1, data 0x22222222. Load 0x202 -> same word, forwarded. SB to 0x204 then load 0x204 -> forward_stall=1.
- Full and arbitration: DEPTH=4, four stores with mem_wr_ready=0 -> buffer_full=1; fifth capture ignored; load_request=1 -> wr_enable stays 1 because full. Release ready -> one drain per cycle, FIFO order preserved.
- Wrap and simultaneous: 10 stores back-to-back with continuous drain -> pointers wrap, count stays at or below 1, all 10 writes appear in order.
- Flush: 3 entries queued, flush_req pulse with load_request held 1 -> 3 writes on consecutive ready cycles, flush_done high exactly one cycle after the third.
- Reset: assert rst=0 with 2 entries pending and ready=0 -> wr_enable drops immediately, buffer_empty=1, no write after release.
